// File: rtl/apu_div_pkg.sv
// Shared encodings for the APU divider channels: the RUN/HALT channel state
// and the periodic/one-shot mode selector.
package apu_div_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } chan_state_e;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/apu_div_chan.sv
// One divider channel: counts ticks down from a reloadable period and raises a
// same-cycle pulse when a tick lands on a zero count while running.
module apu_div_chan
  import apu_div_pkg::*;
#(
  parameter int PERIOD_BITS = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic                   reload,
  input  logic [PERIOD_BITS-1:0] period,
  input  logic                   mode,
  output logic                   pulse,
  output logic                   active,
  output logic [PERIOD_BITS-1:0] cnt
);

  chan_state_e            state_q, state_d;
  logic [PERIOD_BITS-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Mode only matters at terminal count, so a mid-count change waits for zero.
  // The pulse is independent of reload: a coincident reload still lets it out.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse   = tick && (cnt_q == '0) && (state_q == ST_RUN);
    if (reload) begin
      cnt_d   = period;
      state_d = ST_RUN;
    end else if ((state_q == ST_RUN) && tick) begin
      if (cnt_q == '0) begin
        if (mode == MODE_ONESHOT) begin
          state_d = ST_HALT;
        end else begin
          cnt_d = period;
        end
      end else begin
        cnt_d = cnt_q - PERIOD_BITS'(1);
      end
    end
  end

  assign active = (state_q == ST_RUN);
  assign cnt    = cnt_q;

endmodule

// File: rtl/apu_divn.sv
// Bank of independent divider channels sharing one tick; a channel may instead
// take its tick from the previous channel's pulse, forming a combinational chain.
module apu_divn
  import apu_div_pkg::*;
#(
  parameter int PERIOD_BITS = 16,
  parameter int CHANNELS    = 4
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            pulse_in,
  input  logic [CHANNELS-1:0]             reload_in,
  input  logic [CHANNELS*PERIOD_BITS-1:0] period_in,
  input  logic [CHANNELS-1:0]             mode_in,
  input  logic [CHANNELS-1:0]             enable_in,
  input  logic [CHANNELS-1:0]             cascade_in,
  output logic [CHANNELS-1:0]             pulse_out,
  output logic [CHANNELS-1:0]             active_out,
  output logic [CHANNELS*PERIOD_BITS-1:0] cnt_out
);

  for (genvar i = 0; i < CHANNELS; i++) begin : chan_g
    logic                   src;
    logic                   tick;
    logic                   pulse;
    logic                   active;
    logic [PERIOD_BITS-1:0] cnt;

    // Channel 0 has no upstream neighbour, so its cascade bit has no meaning.
    if (i == 0) begin : src0_g
      logic unused_cascade;
      assign unused_cascade = cascade_in[0];
      assign src = pulse_in;
    end else begin : srcn_g
      assign src = cascade_in[i] ? chan_g[i-1].pulse : pulse_in;
    end

    assign tick = enable_in[i] & src;

    apu_div_chan #(
      .PERIOD_BITS(PERIOD_BITS)
    ) u_chan (
      .clk    (clk_in),
      .rst    (rst_in),
      .tick   (tick),
      .reload (reload_in[i]),
      .period (period_in[i*PERIOD_BITS +: PERIOD_BITS]),
      .mode   (mode_in[i]),
      .pulse  (pulse),
      .active (active),
      .cnt    (cnt)
    );

    assign pulse_out[i]                          = pulse;
    assign active_out[i]                         = active;
    assign cnt_out[i*PERIOD_BITS +: PERIOD_BITS] = cnt;
  end

endmodule

// File: tb/tb_apu_divn.sv
// Directed bench for apu_divn: periodic, one-shot, cascade, reload/terminal
// overlap, enable gating, mode change and asynchronous reset.
module tb_apu_divn;

  localparam int PB = 16;
  localparam int CH = 4;

  logic             clk_in;
  logic             rst_in;
  logic             pulse_in;
  logic [CH-1:0]    reload_in;
  logic [CH*PB-1:0] period_in;
  logic [CH-1:0]    mode_in;
  logic [CH-1:0]    enable_in;
  logic [CH-1:0]    cascade_in;
  logic [CH-1:0]    pulse_out;
  logic [CH-1:0]    active_out;
  logic [CH*PB-1:0] cnt_out;

  int errors = 0;
  int checks = 0;

  apu_divn #(
    .PERIOD_BITS(PB),
    .CHANNELS   (CH)
  ) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .pulse_in  (pulse_in),
    .reload_in (reload_in),
    .period_in (period_in),
    .mode_in   (mode_in),
    .enable_in (enable_in),
    .cascade_in(cascade_in),
    .pulse_out (pulse_out),
    .active_out(active_out),
    .cnt_out   (cnt_out)
  );

  // clock block
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // driver tasks: inputs change 2 time units after a rising edge, checks 1 later
  task automatic cyc();
    @(posedge clk_in);
    #2;
  endtask

  task automatic set_period(input int ch, input logic [PB-1:0] v);
    period_in[ch*PB +: PB] = v;
  endtask

  task automatic pulse_reset();
    rst_in = 1'b1;
    #1;
    rst_in = 1'b0;
  endtask

  function automatic logic [PB-1:0] cnt_of(input int ch);
    return cnt_out[ch*PB +: PB];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_in     = 1'b1;
    pulse_in   = 1'b0;
    reload_in  = '0;
    period_in  = '0;
    mode_in    = '0;
    enable_in  = '0;
    cascade_in = '0;
    #1;
    chk("rst_cnt", 32'(cnt_out), 32'd0);
    chk("rst_active", 32'(active_out), 32'hF);
    chk("rst_pulse_idle", 32'(pulse_out), 32'h0);
    enable_in = 4'b0001;
    pulse_in  = 1'b1;
    #1;
    chk("rst_pulse_tick", 32'(pulse_out), 32'h1);
    enable_in = '0;
    pulse_in  = 1'b0;
    cyc();
    rst_in = 1'b0;

    // Periodic: ch0 period 3, ticks every cycle
    cyc();
    set_period(0, 16'd3);
    reload_in = 4'b0001;
    enable_in = 4'b0001;
    pulse_in  = 1'b1;
    #1;
    chk("per_reload_pulse", 32'(pulse_out), 32'h1);
    cyc();
    reload_in = '0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("per_cnt", 32'(cnt_of(0)), 32'(3 - (k % 4)));
      chk("per_pulse", 32'(pulse_out), (k % 4 == 3) ? 32'h1 : 32'h0);
      cyc();
    end

    // One-shot: ch1 period 2
    pulse_reset();
    enable_in = 4'b0010;
    pulse_in  = 1'b0;
    mode_in   = 4'b0010;
    set_period(1, 16'd2);
    reload_in = 4'b0010;
    cyc();
    reload_in = '0;
    pulse_in  = 1'b1;
    for (int k = 0; k < 7; k++) begin
      #1;
      chk("os_cnt", 32'(cnt_of(1)), (k < 3) ? 32'(2 - k) : 32'd0);
      chk("os_pulse", 32'(pulse_out), (k == 2) ? 32'h2 : 32'h0);
      chk("os_active", 32'(active_out[1]), (k < 3) ? 32'd1 : 32'd0);
      cyc();
    end
    reload_in = 4'b0010;
    #1;
    chk("os_halt_reload_pulse", 32'(pulse_out), 32'h0);
    cyc();
    reload_in = '0;
    #1;
    chk("os_rearm_active", 32'(active_out[1]), 32'd1);
    chk("os_rearm_cnt", 32'(cnt_of(1)), 32'd2);
    mode_in = '0;

    // Cascade: ch0 period 1 feeds ch1 period 2
    pulse_reset();
    pulse_in   = 1'b0;
    enable_in  = 4'b0011;
    cascade_in = 4'b0010;
    set_period(0, 16'd1);
    set_period(1, 16'd2);
    reload_in  = 4'b0011;
    cyc();
    reload_in = '0;
    pulse_in  = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      chk("cas_cnt0", 32'(cnt_of(0)), 32'(1 - (k % 2)));
      chk("cas_cnt1", 32'(cnt_of(1)), 32'(2 - (k % 6) / 2));
      chk("cas_pulse", 32'(pulse_out), (k % 6 == 5) ? 32'h3 : ((k % 2 == 1) ? 32'h1 : 32'h0));
      cyc();
    end
    cascade_in = '0;

    // Reload coinciding with terminal tick on ch3
    pulse_reset();
    enable_in = 4'b1000;
    pulse_in  = 1'b1;
    set_period(3, 16'd5);
    reload_in = 4'b1000;
    #1;
    chk("sim_pulse", 32'(pulse_out), 32'h8);
    cyc();
    reload_in = '0;
    #1;
    chk("sim_cnt", 32'(cnt_of(3)), 32'd5);
    chk("sim_pulse_after", 32'(pulse_out), 32'h0);

    // Enable gating on ch2 at count 4
    pulse_reset();
    pulse_in  = 1'b0;
    enable_in = 4'b0100;
    set_period(2, 16'd6);
    reload_in = 4'b0100;
    cyc();
    reload_in = '0;
    pulse_in  = 1'b1;
    cyc();
    cyc();
    #1;
    chk("gate_pre", 32'(cnt_of(2)), 32'd4);
    enable_in = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      cyc();
      #1;
      chk("gate_hold_cnt", 32'(cnt_of(2)), 32'd4);
      chk("gate_hold_pulse", 32'(pulse_out), 32'h0);
    end
    enable_in = 4'b0100;
    cyc();
    #1;
    chk("gate_resume3", 32'(cnt_of(2)), 32'd3);
    cyc();
    #1;
    chk("gate_resume2", 32'(cnt_of(2)), 32'd2);

    // Mode change mid-count takes effect at the next zero
    pulse_reset();
    pulse_in  = 1'b0;
    enable_in = 4'b0001;
    mode_in   = '0;
    set_period(0, 16'd2);
    reload_in = 4'b0001;
    cyc();
    reload_in = '0;
    pulse_in  = 1'b1;
    cyc();
    mode_in = 4'b0001;
    cyc();
    #1;
    chk("mode_cnt0", 32'(cnt_of(0)), 32'd0);
    chk("mode_pulse", 32'(pulse_out), 32'h1);
    cyc();
    #1;
    chk("mode_halt", 32'(active_out[0]), 32'd0);
    mode_in = '0;

    // Asynchronous reset mid-count on ch2 at count 7
    pulse_reset();
    pulse_in  = 1'b0;
    enable_in = 4'b0100;
    set_period(2, 16'd9);
    reload_in = 4'b0100;
    cyc();
    reload_in = '0;
    pulse_in  = 1'b1;
    cyc();
    cyc();
    #1;
    chk("arst_pre", 32'(cnt_of(2)), 32'd7);
    #2;
    rst_in = 1'b1;
    #1;
    chk("arst_cnt", 32'(cnt_out), 32'd0);
    chk("arst_active", 32'(active_out), 32'hF);
    chk("arst_pulse", 32'(pulse_out), 32'h4);
    #1;
    rst_in = 1'b0;
    cyc();
    #1;
    chk("arst_resume", 32'(cnt_of(2)), 32'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apu_divn.md
APU_DIVN -- requirements
Module: apu_divn

Interface
REQ-001 SHALL have parameter PERIOD_BITS, default 16, counter/period width per channel (legal 1..32).
REQ-002 SHALL have parameter CHANNELS, default 4, number of independent divider channels (legal 1..8).
REQ-003 SHALL have port clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_in  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port pulse_in  input  1  shared tick; one-cycle qualifier for decrementing.
REQ-006 SHALL have port reload_in  input  CHANNELS  per-channel reload strobe.
REQ-007 SHALL have port period_in  input  CHANNELS*PERIOD_BITS  packed periods; channel i in bits [i*PERIOD_BITS +: PERIOD_BITS].
REQ-008 SHALL have port mode_in  input  CHANNELS  per-channel mode: 0 = periodic, 1 = one-shot.
REQ-009 SHALL have port enable_in  input  CHANNELS  per-channel tick enable.
REQ-010 SHALL have port cascade_in  input  CHANNELS  per-channel tick source: 0 = pulse_in, 1 = pulse_out of channel i-1; bit 0 ignored.
REQ-011 SHALL have port pulse_out  output  CHANNELS  per-channel terminal-count pulse, combinational.
REQ-012 SHALL have port active_out  output  CHANNELS  1 = channel in RUN state.
REQ-013 SHALL have port cnt_out  output  CHANNELS*PERIOD_BITS  packed current counts, same packing as period_in.

Function
REQ-014 SHALL compute per-channel tick t_i = enable_in[i] AND (cascade_in[i] AND i>0 ? pulse_out[i-1] : pulse_in).
REQ-015 SHALL hold per-channel state RUN or HALT plus counter cnt_i.
REQ-016 SHALL drive pulse_out[i] = t_i AND (cnt_i == 0) AND state RUN, same cycle (zero latency); a cascade chain SHALL settle within one cycle.
REQ-017 SHALL, on reload_in[i], load cnt_i <= period_in slice and enter RUN, regardless of tick, mode or state.
REQ-018 SHALL, when reload_in[i] and pulse_out[i] coincide, still emit the pulse; reload value wins for next count.
REQ-019 SHALL, in RUN, no reload, t_i and cnt_i == 0: periodic -> cnt_i <= period; one-shot -> cnt_i stays 0, state <= HALT.
REQ-020 SHALL, in RUN, no reload, t_i and cnt_i != 0, decrement cnt_i by 1 (no wrap possible).
REQ-021 SHALL hold cnt_i and state when t_i is 0 and no reload.
REQ-022 SHALL, in HALT, ignore ticks; no pulses until reload.
REQ-023 SHALL, for period 0 in periodic mode, pulse on every tick; in one-shot, pulse on first tick then HALT.
REQ-024 SHALL give periodic output rate of one pulse per (period+1) ticks.
REQ-025 SHALL sample mode_in only at terminal count; changing mode mid-count SHALL take effect at next zero.
REQ-026 SHALL keep channels fully independent except via cascade.

Reset
REQ-027 SHALL, on rst_in high, asynchronously set every cnt_i = 0 and state = RUN, so pulse_out = t_i and active_out all 1s, cnt_out 0.
REQ-028 SHALL resume normal operation on the first clock edge after rst_in deasserts; reset mid-count discards count.

Structure
REQ-029 SHALL place state encoding (RUN/HALT) and mode encoding (PERIODIC/ONESHOT) constants in shared package apu_div_pkg.
REQ-030 SHALL implement one channel as sub-module apu_div_chan (tick, reload, period, mode in; pulse, active, cnt out), instantiated CHANNELS times via generate; cascade wiring in apu_divn.

Verification
REQ-031 SHALL cover periodic: PERIOD_BITS=16, ch0 reload period 3, pulse_in every cycle -> pulse_out[0] every 4th cycle, cnt_out 3,2,1,0 repeating.
REQ-032 SHALL cover one-shot: ch1 mode 1, reload period 2, ticks continuous -> exactly one pulse 3 ticks after reload, active_out[1] falls next cycle, no further pulses until reload.
REQ-033 SHALL cover cascade: ch0 period 1, ch1 cascade_in=1 period 2, pulse_in continuous -> ch1 pulses once per 6 pulse_in ticks, coincident with a ch0 pulse.
REQ-034 SHALL cover simultaneous reload and terminal tick: cnt 0, tick and reload period 5 same cycle -> pulse_out high that cycle, cnt_out 5 next.
REQ-035 SHALL cover enable gating: enable_in[2]=0 for 10 ticks mid-count at cnt 4 -> cnt holds 4, no pulse; resumes decrement when re-enabled.
REQ-036 SHALL cover async reset mid-count: assert rst_in between clock edges at cnt 7 -> cnt_out 0 and active_out all 1s immediately, before next edge.
